lc3b_mem_responder: RTL

Memory-side responder for the LC-3b datapath's memory interface. It accepts a request (MIO_EN with byte address, direction, size and write data), holds it for a fixed access latency, performs a word or byte write or a word read on its internal array, and pulses the ready signal `R` for one cycle. The microsequencer sits in a memory state until `R` is seen. The block replaces the ideal memory model and sits opposite the MAR/MDR logic.

---
 rtl/lc3b_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lc3b_mem_responder.sv
// Fixed-latency memory responder for the LC-3b memory interface: captures a request,
// waits LATENCY cycles of requester occupancy, performs a word/byte access and pulses R.
module lc3b_mem_responder #(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MIO_EN,
   input  logic        R_W,
   input  logic        DATA_SIZE,
   input  logic [15:0] ADDR,
   input  logic [15:0] DATA_IN,
   output logic [15:0] DATA_OUT,
   output logic        R
);

   localparam int         DEPTH    = 2 ** ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

   state_t                state;
   logic [3:0]            cnt;

   logic [ADDR_WIDTH-1:0] idx_p0;
   logic                  hi_p0;
   logic                  rw_p0;
   logic                  size_p0;
   logic [15:0]           data_p0;

   logic [15:0]           mem [DEPTH];

   logic                  capture;
   logic                  direct_acc;
   logic                  wait_acc;
   logic                  do_acc;
   logic [ADDR_WIDTH-1:0] acc_idx;
   logic                  acc_hi;
   logic                  acc_rw;
   logic                  acc_size;
   logic [15:0]           acc_data;
   logic [15:0]           old_word;
   logic [15:0]           new_word;

   // Address bits above the word index alias and are deliberately ignored.
   logic                  unused_addr;
   assign unused_addr = ^ADDR;

   function automatic logic [15:0] merge_write(input logic [15:0] old_w,
                                               input logic [15:0] wr_d,
                                               input logic        size,
                                               input logic        hi);
      logic [15:0] res;
      if (size)
         res = wr_d;
      else if (hi)
         res = {wr_d[15:8], old_w[7:0]};
      else
         res = {old_w[15:8], wr_d[7:0]};
      return res;
   endfunction

   // With LATENCY=2 the access happens on the capture edge itself, so the live
   // inputs are used; otherwise only the latched request fields matter.
   always_comb begin
      capture    = (state == IDLE) && MIO_EN;
      direct_acc = capture && (CNT_INIT == 4'd0);
      wait_acc   = (state == WAIT) && (cnt == 4'd1);
      do_acc     = direct_acc || wait_acc;
      acc_idx    = direct_acc ? ADDR[ADDR_WIDTH:1] : idx_p0;
      acc_hi     = direct_acc ? ADDR[0]            : hi_p0;
      acc_rw     = direct_acc ? R_W                : rw_p0;
      acc_size   = direct_acc ? DATA_SIZE          : size_p0;
      acc_data   = direct_acc ? DATA_IN            : data_p0;
      old_word   = mem[acc_idx];
      new_word   = acc_rw ? merge_write(old_word, acc_data, acc_size, acc_hi) : old_word;
   end

   // Stage p0: request capture
   always_ff @(posedge clk) begin
      if (capture) begin
         idx_p0  <= ADDR[ADDR_WIDTH:1];
         hi_p0   <= ADDR[0];
         rw_p0   <= R_W;
         size_p0 <= DATA_SIZE;
         data_p0 <= DATA_IN;
      end
   end

   // Array contents survive reset; a write pending at a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (do_acc && acc_rw && !reset)
         mem[acc_idx] <= new_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         R        <= 1'b0;
         DATA_OUT <= 16'h0000;
      end else begin
         R <= 1'b0;
         case (state)
            IDLE: begin
               if (MIO_EN) begin
                  cnt <= CNT_INIT;
                  if (CNT_INIT == 4'd0) begin
                     state    <= DONE;
                     R        <= 1'b1;
                     DATA_OUT <= new_word;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (wait_acc) begin
                  state    <= DONE;
                  R        <= 1'b1;
                  DATA_OUT <= new_word;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule
